// File: rtl/fifo_flex_pkg.sv
// Shared constants and elaboration helpers for fifo_flex.
// Holds the minimum legal depth, level-width derivation and parameter sanity check.
package fifo_flex_pkg;

  localparam int FIFO_FLEX_MIN_DEPTH = 2;

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  // True when the depth and almost-full threshold describe a buildable FIFO.
  function automatic bit params_ok(input int depth, input int af_thresh);
    return (depth >= FIFO_FLEX_MIN_DEPTH) && (af_thresh <= depth + 1);
  endfunction

endpackage

// File: rtl/fifo_flex_ptr.sv
// Modulo-DEPTH pointer with synchronous clear and increment (any DEPTH >= 2).
// Latency: new value visible the cycle after inc.
// Backpressure: none; the caller only pulses inc on accepted operations.
module fifo_flex_ptr #(
  parameter int DEPTH = 6,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_flex.sv
// Any-depth FIFO with registered FWFT output, level, almost flags and flush; FIFO_FLEX_BYPASS_EN enables empty-FIFO bypass.
// Latency: push to output_valid is 1 cycle with bypass, 2 without; 1 word/cycle sustained.
// Backpressure: input_ready drops when memory holds DEPTH words or during flush; a same-cycle pop does not free a slot.
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 6,
  parameter int AF_THRESH = DEPTH,
  parameter int AE_THRESH = 1,
  parameter int LVL_W     = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] din,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] qout,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [LVL_W-1:0] level,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (!params_ok(DEPTH, AF_THRESH)) begin : g_bad_params
    $error("fifo_flex: DEPTH must be >= 2 and AF_THRESH <= DEPTH+1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem_count;
  logic             clr;
  logic             push;
  logic             pop;
  logic             load_slot;
  logic             xfer;
  logic             byp;
  logic             mem_wr;

  assign clr         = rst_in || flush_in;
  assign input_ready = (mem_count != CNT_W'(DEPTH)) && !flush_in;
  assign push        = input_valid && input_ready;
  assign pop         = output_valid && output_ready && !flush_in;
  assign load_slot   = !output_valid || pop;
  assign xfer        = load_slot && (mem_count != '0) && !clr;

`ifdef FIFO_FLEX_BYPASS_EN
  // Only taken with memory empty, so it can never overtake a stored word.
  assign byp = load_slot && (mem_count == '0) && push && !rst_in;
`else
  assign byp = 1'b0;
`endif

  assign mem_wr = push && !byp && !rst_in;

  fifo_flex_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .clr (clr),
    .inc (mem_wr),
    .ptr (wr_ptr)
  );

  fifo_flex_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .clr (clr),
    .inc (xfer),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      mem_count    <= '0;
      output_valid <= 1'b0;
      qout         <= '0;
    end else if (flush_in) begin
      mem_count    <= '0;
      output_valid <= 1'b0;
    end else begin
      if (mem_wr && !xfer) begin
        mem_count <= mem_count + CNT_W'(1);
      end else if (!mem_wr && xfer) begin
        mem_count <= mem_count - CNT_W'(1);
      end

      if (xfer) begin
        qout         <= mem[rd_ptr];
        output_valid <= 1'b1;
      end else if (byp) begin
        qout         <= din;
        output_valid <= 1'b1;
      end else if (pop) begin
        output_valid <= 1'b0;
      end
    end
  end

  assign level        = LVL_W'(mem_count) + LVL_W'(output_valid);
  assign almost_full  = int'(level) >= AF_THRESH;
  assign almost_empty = int'(level) <= AE_THRESH;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex (DEPTH=5, AF_THRESH=4, AE_THRESH=1), valid in both bypass builds.
// A queue model predicts every output each cycle; directed phases pin it with literal values.
module tb_fifo_flex;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int LVL_W = $clog2(DEPTH + 2);
`ifdef FIFO_FLEX_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_in;
  logic             flush_in;
  logic [WIDTH-1:0] din;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] qout;
  logic             output_valid;
  logic             output_ready;
  logic [LVL_W-1:0] level;
  logic             almost_full;
  logic             almost_empty;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit check_en = 1'b0;

  logic [WIDTH-1:0] mq[$];   // model contents, head first
  bit               m_ov;    // model: head word visible on qout
  logic [WIDTH-1:0] got[$];  // words actually popped from the DUT
  int               gotc[$]; // cycle stamp of each pop

  fifo_flex #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .flush_in     (flush_in),
    .din          (din),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .qout         (qout),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a word is visible once any word sits in the FIFO, except that without
  // bypass a word pushed at this edge into an otherwise drained FIFO needs one more edge.
  always @(posedge clk) begin
    int  prev;
    int  memc;
    bit  push;
    bit  pop;
    prev = mq.size();
    memc = prev - int'(m_ov);
    if (rst_in || flush_in) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      push = input_valid && (memc != DEPTH);
      pop  = m_ov && output_ready;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(din);
`ifdef FIFO_FLEX_BYPASS_EN
      m_ov = mq.size() > 0;
`else
      m_ov = (prev - int'(pop)) > 0;
`endif
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_in && !flush_in && output_valid && output_ready) begin
      got.push_back(qout);
      gotc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("output_valid", output_valid, m_ov);
      if (m_ov) chk("qout", qout, mq[0]);
      chk("level", level, mq.size());
      chk("input_ready", input_ready, ((mq.size() - int'(m_ov)) != DEPTH) && !flush_in);
      chk("almost_full", almost_full, mq.size() >= AF);
      chk("almost_empty", almost_empty, mq.size() <= AE);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ov"}, output_valid, 1'b0);
    chk({tag, "_qout"}, qout, 32'h0);
    chk({tag, "_ir"}, input_ready, 1'b1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_ae"}, almost_empty, 1'b1);
    chk({tag, "_af"}, almost_full, 1'b0);
  endtask

  task automatic drain(input int n);
    int t = 0;
    output_ready = 1'b1;
    while (got.size() < n && t < 200) begin
      step();
      t++;
    end
    output_ready = 1'b0;
    chk("drain_count", got.size(), n);
  endtask

  initial begin
    bit exp_af[7];
    bit exp_ae[7];
    int n;
    exp_af = '{0, 0, 0, 0, 1, 1, 1};
    exp_ae = '{1, 1, 0, 0, 0, 0, 0};

    rst_in = 1'b1; flush_in = 1'b0; din = '0;
    input_valid = 1'b0; output_ready = 1'b0;
    step();
    check_en = 1'b1;
    step();
    rst_in = 1'b0;
    reset_checks("reset");

    // Fill to capacity, then offer a 7th word that must be refused.
    for (int i = 1; i <= 6; i++) begin
      din = i; input_valid = 1'b1;
      step();
      if (i == 5) chk("fill_ir_after5", input_ready, 1'b1);
    end
    chk("fill_level", level, 6);
    chk("fill_ir", input_ready, 1'b0);
    chk("fill_af", almost_full, 1'b1);
    din = 7;
    step();
    input_valid = 1'b0;
    chk("fill_level_7th", level, 6);
    got.delete(); gotc.delete();
    drain(6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("drain_order", got[i], i + 1);

    // Continuous push+pop across several pointer wraps.
    step();
    got.delete(); gotc.delete();
    output_ready = 1'b1;
    for (int i = 0; i < 23; i++) begin
      din = 100 + i; input_valid = 1'b1;
      step();
    end
    input_valid = 1'b0;
    drain(23);
    for (int i = 0; i < 23 && i < got.size(); i++) chk("wrap_order", got[i], 100 + i);
    for (int i = 1; i < 23 && i < gotc.size(); i++) chk("wrap_rate", gotc[i] - gotc[i-1], 1);

    // Single push into an empty FIFO.
    step();
    got.delete(); gotc.delete();
    din = 32'hAB; input_valid = 1'b1;
    step();
    input_valid = 1'b0;
    n = 1;
    while (!output_valid && n < 5) begin
      step();
      n++;
    end
    chk("latency", n, LAT);
    chk("latency_qout", qout, 32'hAB);
    drain(1);

    // Flush at level 4 with a word offered in the same cycle.
    got.delete(); gotc.delete();
    for (int i = 0; i < 4; i++) begin
      din = 200 + i; input_valid = 1'b1;
      step();
    end
    input_valid = 1'b0;
    step();
    chk("preflush_level", level, 4);
    flush_in = 1'b1; input_valid = 1'b1; din = 32'hDEAD;
    step();
    flush_in = 1'b0; input_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_ov", output_valid, 1'b0);
    din = 300; input_valid = 1'b1; step();
    din = 301; step();
    input_valid = 1'b0;
    drain(2);
    step(); step();
    chk("flush_total", got.size(), 2);
    if (got.size() >= 2) begin
      chk("flush_w0", got[0], 300);
      chk("flush_w1", got[1], 301);
    end

    // Threshold sweep from empty to full.
    chk("thr_level0", level, 0);
    chk("thr_af0", almost_full, exp_af[0]);
    chk("thr_ae0", almost_empty, exp_ae[0]);
    for (int k = 1; k <= 6; k++) begin
      din = 400 + k; input_valid = 1'b1;
      step();
      chk("thr_level", level, k);
      chk("thr_af", almost_full, exp_af[k]);
      chk("thr_ae", almost_empty, exp_ae[k]);
    end
    input_valid = 1'b0;

    // Reset in the middle of traffic.
    output_ready = 1'b1; input_valid = 1'b1; din = 500;
    step(); step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0; input_valid = 1'b0; output_ready = 1'b0;
    reset_checks("midreset");
    step();

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised successor to the power-of-two FIFO. It supports any depth ≥ 2 (non-power-of-two pointer wrap), a registered first-word-fall-through output stage, a fill-level output, programmable almost-full/almost-empty flags, and a synchronous flush. It sits between streaming producers and consumers in the datapath, using the same valid/ready handshake on both sides.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 6: memory entries. Any integer ≥ 2. Total capacity is DEPTH+1 words (memory plus output register).
- AF_THRESH, DEPTH: almost_full asserts when level ≥ AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when level ≤ AE_THRESH.
- LVL_W, $clog2(DEPTH+2): level width. Derived; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_in  in  1  reset. Synchronous, active-high.
- flush_in  in  1  synchronous flush; discards all stored words.
- din  in  WIDTH  write data.
- input_valid  in  1  producer has data.
- input_ready  out  1  FIFO accepts data.
- qout  out  WIDTH  head word; registered.
- output_valid  out  1  qout holds a valid word.
- output_ready  in  1  consumer takes the head word.
- level  out  LVL_W  words held (memory count + output_valid).
- almost_full  out  1  level ≥ AF_THRESH.
- almost_empty  out  1  level ≤ AE_THRESH.

## Operation
- Push occurs when input_valid && input_ready. Pop occurs when output_valid && output_ready.
- input_ready = (mem_count != DEPTH) && !flush_in. It depends on the current state only; a same-cycle pop does not free a slot for a same-cycle push.
- Pointers wr_ptr and rd_ptr range over 0..DEPTH-1 and wrap from DEPTH-1 to 0. mem_count is a separate 0..DEPTH counter.
  - push only: +1.
  - memory-to-output transfer only: −1.
  - both: unchanged.
- Memory read is combinational: head = mem[rd_ptr].
- The output stage loads when (!output_valid || pop) holds and a source word exists:
  - If mem_count > 0, load head, advance rd_ptr, and decrement mem_count.
  - Otherwise, with bypass (see Configuration), load din when a push occurs.
  - Otherwise, output_valid falls after a pop.
- Ordering is strictly FIFO. Bypass is only taken when memory is empty, so it never reorders.
- level = mem_count + output_valid. almost_full and almost_empty are combinational from registered state.
- Flush: on the edge where flush_in = 1, pointers, mem_count and output_valid clear to 0. Any push or pop in that cycle is ignored.
- Flush and reset have identical effect on control state. The memory array itself is not cleared.

## Timing
- Reset values (after an rst_in edge, including mid-transfer):
  - output_valid 0, qout 0.
  - input_ready 1, level 0.
  - almost_empty 1, almost_full 0 (when AF_THRESH > 0).
  - All pointers and counters 0.
- Push-to-output_valid latency into an empty FIFO:
  - 1 cycle with bypass.
  - 2 cycles without bypass (write edge, then transfer edge).
- Steady-state throughput is 1 word/cycle with simultaneous push and pop, in both modes.
- Full: level = DEPTH+1 and input_ready = 0. A pop in that cycle raises input_ready one cycle later.
- Empty: output_valid = 0; output_ready is ignored.
- rst_in takes priority over flush_in, and flush_in over push/pop.

## Configuration
- FIFO_FLEX_BYPASS_EN:
  - Defined: when mem_count = 0 and the output stage is empty or popping, a push writes din straight into the output register and not into memory. Latency is 1.
  - Undefined: every word passes through memory. Latency is 2; behaviour is otherwise identical.

## Structure
- Package fifo_flex_pkg holds:
  - FIFO_FLEX_MIN_DEPTH = 2;
  - the function lvl_width(depth), returning $clog2(depth+2);
  - an elaboration-time check that fails if DEPTH < FIFO_FLEX_MIN_DEPTH or AF_THRESH > DEPTH+1.
- Sub-module fifo_flex_ptr implements a modulo-DEPTH pointer with clear and increment. It is instantiated twice, for wr_ptr and rd_ptr.
- The storage array and output register are inline.

## Test plan
- Reset release:
  - Stimulus: assert rst_in for 2 cycles, then release it.
  - Response: output_valid=0, input_ready=1, level=0, almost_empty=1, almost_full=0.
- Fill with DEPTH=5, output_ready=0:
  - Stimulus: push 0x01..0x06.
  - Response: level reaches 6, input_ready falls after the 6th push, and a 7th push (0x07) is not accepted.
  - Then drain: qout sequence 0x01..0x06, in order.
- Wrap-around with DEPTH=5:
  - Stimulus: 23 words pushed and popped continuously.
  - Response: output order matches input order, with one word per cycle after the first.
- Latency:
  - Stimulus: a single push into an empty FIFO.
  - Response: output_valid rises 1 cycle later with FIFO_FLEX_BYPASS_EN defined, 2 cycles later without it.
- Flush mid-stream:
  - Stimulus: with level=4, assert flush_in for 1 cycle while input_valid=1.
  - Response: next cycle level=0, output_valid=0, and the flush-cycle word is absent from later output.
- Thresholds with AF_THRESH=4, AE_THRESH=1:
  - Response: almost_full is 1 exactly when level ≥ 4; almost_empty is 1 exactly when level ≤ 1.
